// File: rtl/motor_movement_executor.sv
// motor_movement_executor: runs one quarter/half cube-face turn on the selected stepper and pulses completion.
module motor_movement_executor #(
    parameter int STEPS_90      = 50,
    parameter int HALF_PERIOD   = 25000,
    parameter int SETUP_CYCLES  = 500,
    parameter int SETTLE_CYCLES = 100000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       aciona_movimento,
    input  logic [4:0] movimento,
    output logic [5:0] step_out,
    output logic [5:0] dir_out,
    output logic [5:0] motor_en,
    output logic       fim_movimento,
    output logic       erro_movimento,
    output logic       ocupado,
    output logic [3:0] db_estado
);
    localparam int MAXC = (HALF_PERIOD > SETUP_CYCLES)
                        ? ((HALF_PERIOD > SETTLE_CYCLES) ? HALF_PERIOD : SETTLE_CYCLES)
                        : ((SETUP_CYCLES > SETTLE_CYCLES) ? SETUP_CYCLES : SETTLE_CYCLES);
    localparam int PW = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int SW = $clog2(2 * STEPS_90 + 1);
    // DONE itself is the final settle cycle, so SETTLE holds one cycle less
    localparam int SETTLE_LAST = (SETTLE_CYCLES > 1) ? SETTLE_CYCLES - 2 : 0;

    typedef enum logic [3:0] {
        IDLE         = 4'd0,
        SETUP        = 4'd1,
        STEP_HIGH    = 4'd2,
        STEP_LOW     = 4'd3,
        SETTLE       = 4'd4,
        DONE         = 4'd5,
        WAIT_RELEASE = 4'd6
    } state_t;

    state_t        state;
    logic [PW-1:0] cnt;
    logic [SW-1:0] steps;
    logic [SW-1:0] target;

    assign fim_movimento = state == DONE;
    assign ocupado       = state != IDLE && state <= WAIT_RELEASE;
    assign db_estado     = (state > WAIT_RELEASE) ? 4'hF : 4'(state);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state          <= IDLE;
            cnt            <= '0;
            steps          <= '0;
            target         <= '0;
            step_out       <= '0;
            dir_out        <= '0;
            motor_en       <= '0;
            erro_movimento <= 1'b0;
        end else begin
            step_out <= '0;
            case (state)
                IDLE: if (aciona_movimento) begin
                    cnt            <= '0;
                    steps          <= '0;
                    target         <= (movimento[1:0] == 2'b10) ? SW'(2 * STEPS_90) : SW'(STEPS_90);
                    erro_movimento <= movimento[4:2] > 3'd5;
                    if (movimento[4:2] > 3'd5 || movimento[1:0] == 2'b00) begin
                        state <= DONE;
                    end else begin
                        state    <= SETUP;
                        motor_en <= 6'd1 << movimento[4:2];
                        dir_out  <= (movimento[1:0] == 2'b11) ? 6'd0 : 6'd1 << movimento[4:2];
                    end
                end
                SETUP: if (cnt == PW'(SETUP_CYCLES - 1)) begin
                    cnt      <= '0;
                    state    <= STEP_HIGH;
                    step_out <= motor_en;
                end else begin
                    cnt <= cnt + PW'(1);
                end
                STEP_HIGH: if (cnt == PW'(HALF_PERIOD - 1)) begin
                    cnt   <= '0;
                    state <= STEP_LOW;
                end else begin
                    cnt      <= cnt + PW'(1);
                    step_out <= motor_en;
                end
                STEP_LOW: if (cnt == PW'(HALF_PERIOD - 1)) begin
                    cnt   <= '0;
                    steps <= steps + SW'(1);
                    if (steps + SW'(1) != target) begin
                        state    <= STEP_HIGH;
                        step_out <= motor_en;
                    end else if (SETTLE_CYCLES > 1) begin
                        state <= SETTLE;
                    end else begin
                        state    <= DONE;
                        motor_en <= '0;
                        dir_out  <= '0;
                    end
                end else begin
                    cnt <= cnt + PW'(1);
                end
                SETTLE: if (cnt == PW'(SETTLE_LAST)) begin
                    cnt      <= '0;
                    state    <= DONE;
                    motor_en <= '0;
                    dir_out  <= '0;
                end else begin
                    cnt <= cnt + PW'(1);
                end
                DONE: state <= WAIT_RELEASE;
                WAIT_RELEASE: if (!aciona_movimento) state <= IDLE;
                default: begin
                    state    <= IDLE;
                    cnt      <= '0;
                    steps    <= '0;
                    motor_en <= '0;
                    dir_out  <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_motor_movement_executor.sv
// tb_motor_movement_executor: table-driven move vectors plus reset and release corner cases.
module tb_motor_movement_executor;
    localparam int S = 3, H = 2, N90 = 4, T = 5;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       aciona_movimento = 1'b0;
    logic [4:0] movimento = 5'd0;
    logic [5:0] step_out, dir_out, motor_en;
    logic       fim_movimento, erro_movimento, ocupado;
    logic [3:0] db_estado;

    motor_movement_executor #(
        .STEPS_90(N90), .HALF_PERIOD(H), .SETUP_CYCLES(S), .SETTLE_CYCLES(T)
    ) dut (
        .clock(clock), .reset(reset), .aciona_movimento(aciona_movimento),
        .movimento(movimento), .step_out(step_out), .dir_out(dir_out),
        .motor_en(motor_en), .fim_movimento(fim_movimento),
        .erro_movimento(erro_movimento), .ocupado(ocupado), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int failed = 0;
    bit prev_err = 1'b0;

    typedef struct {
        logic [4:0] mov;
        logic [4:0] alt;
        int         n;
        bit         dir;
        bit         err;
        bit         noop;
    } vec_t;

    vec_t vecs[8];

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int all_outs();
        return int'({step_out, dir_out, motor_en, fim_movimento, erro_movimento, ocupado, db_estado});
    endfunction

    task automatic run_move(input vec_t v, input int idx);
        int L, pulses, bad_step, bad_en, bad_dir, bad_err, bad_busy, fim_cyc, fim_cnt;
        logic [5:0] f, en_e, st_e, prev_step;
        f = v.noop ? 6'd0 : 6'd1 << v.mov[4:2];
        L = v.noop ? 1 : S + 2 * H * v.n + T;
        {pulses, bad_step, bad_en, bad_dir, bad_err, bad_busy, fim_cyc, fim_cnt} = '0;
        prev_step = '0;
        check($sformatf("v%0d erro_before", idx), int'(erro_movimento), int'(prev_err));
        movimento = v.mov;
        aciona_movimento = 1'b1;
        tick;
        for (int c = 1; c <= L + 3; c++) begin
            en_e = (!v.noop && c < L) ? f : 6'd0;
            st_e = (!v.noop && c > S && c <= S + 2 * H * v.n && ((c - S - 1) % (2 * H)) < H) ? f : 6'd0;
            if (step_out != st_e) bad_step++;
            if (motor_en != en_e) bad_en++;
            if (dir_out != (v.dir ? en_e : 6'd0)) bad_dir++;
            if (erro_movimento != v.err) bad_err++;
            if (!ocupado) bad_busy++;
            if (fim_movimento) begin
                fim_cnt++;
                fim_cyc = c;
            end
            if (|(step_out & ~prev_step)) pulses++;
            prev_step = step_out;
            if (c == 5) movimento = v.alt;
            tick;
        end
        check($sformatf("v%0d step_pattern", idx), bad_step, 0);
        check($sformatf("v%0d pulses", idx), pulses, v.n);
        check($sformatf("v%0d motor_en", idx), bad_en, 0);
        check($sformatf("v%0d dir_out", idx), bad_dir, 0);
        check($sformatf("v%0d erro", idx), bad_err, 0);
        check($sformatf("v%0d ocupado", idx), bad_busy, 0);
        check($sformatf("v%0d fim_count", idx), fim_cnt, 1);
        check($sformatf("v%0d fim_cycle", idx), fim_cyc, L);
        check($sformatf("v%0d wait_release", idx), int'(db_estado), 6);
        aciona_movimento = 1'b0;
        tick;
        check($sformatf("v%0d idle_after", idx), int'({db_estado, ocupado}), 0);
        prev_err = v.err;
    endtask

    initial begin
        int fims;
        vecs[0] = '{5'b01001, 5'b01001, 4, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{5'b10110, 5'b10110, 8, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{5'b00011, 5'b10101, 4, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{5'b11001, 5'b11001, 0, 1'b0, 1'b1, 1'b1};
        vecs[4] = '{5'b00101, 5'b00101, 4, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{5'b01100, 5'b01100, 0, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{5'b10011, 5'b01010, 4, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{5'b11110, 5'b11110, 0, 1'b0, 1'b1, 1'b1};

        tick;
        tick;
        check("reset_idle", all_outs(), 0);
        reset = 1'b1;
        tick;
        check("idle_quiet", all_outs(), 0);

        for (int i = 0; i < 8; i++) run_move(vecs[i], i);

        check("erro_sticky_idle", int'(erro_movimento), 1);
        reset = 1'b0;
        tick;
        tick;
        check("reset_clears_erro", all_outs(), 0);
        reset = 1'b1;
        tick;

        movimento = 5'b01001;
        aciona_movimento = 1'b1;
        tick;
        repeat (8) tick;
        check("midmove_active", int'(step_out | motor_en), 6'b000100);
        reset = 1'b0;
        aciona_movimento = 1'b0;
        tick;
        tick;
        check("reset_midmove", all_outs(), 0);
        reset = 1'b1;
        fims = 0;
        for (int c = 0; c < 30; c++) begin
            if (fim_movimento || motor_en != 6'd0) fims++;
            tick;
        end
        check("no_fim_after_reset", fims, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
